// File: rtl/crc_frame_rx.sv
// Serial frame receiver: start, 8 data bits, 6 CRC bits and a stop bit, all MSB first.
// Latency: frame_valid/frame_err and the d/crc update are visible in the cycle after the stop strobe or timeout.
// Backpressure: none; the upstream tick generator paces the bits, and the checker must accept every pulse.
module crc_frame_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_bit,
  input  logic       bit_strobe,
  output logic [7:0] d,
  output logic [5:0] crc,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, CRC, STOP} state_t;

  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  dsr_q, dsr_d, d_q, d_d;
  logic [5:0]  csr_q, csr_d, crc_q, crc_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        timeout, stop_ok, stop_bad;

  // A strobe in the limit cycle wins over the timeout.
  assign timeout = (state_q != IDLE) && !bit_strobe &&
                   (({1'b0, idle_cnt_q} + 17'd1) == TMO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (timeout) begin
      state_d = IDLE;
    end else if (bit_strobe) begin
      case (state_q)
        IDLE: if (!rx_bit) state_d = DATA;
        DATA: if (bit_cnt_q == 4'd7) state_d = CRC;
        CRC:  if (bit_cnt_q == 4'd5) state_d = STOP;
        STOP: begin
          state_d  = IDLE;
          stop_ok  = rx_bit;
          stop_bad = !rx_bit;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    dsr_d         = dsr_q;
    csr_d         = csr_q;
    d_d           = d_q;
    crc_d         = crc_q;
    err_code_d    = err_code_q;
    frame_valid_d = stop_ok;
    frame_err_d   = stop_bad || timeout;
    idle_cnt_d    = (state_d == IDLE || bit_strobe) ? 16'd0 : idle_cnt_q + 16'd1;
    if (bit_strobe) begin
      case (state_q)
        IDLE: bit_cnt_d = 4'd0;
        DATA: begin
          dsr_d     = {dsr_q[6:0], rx_bit};
          bit_cnt_d = (bit_cnt_q == 4'd7) ? 4'd0 : bit_cnt_q + 4'd1;
        end
        CRC: begin
          csr_d     = {csr_q[4:0], rx_bit};
          bit_cnt_d = (bit_cnt_q == 4'd5) ? 4'd0 : bit_cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
    if (stop_ok) begin
      d_d        = dsr_q;
      crc_d      = csr_q;
      err_code_d = 2'b00;
    end
    if (stop_bad) err_code_d = 2'b01;
    if (timeout)  err_code_d = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      dsr_q         <= '0;
      csr_q         <= '0;
      d_q           <= '0;
      crc_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'b00;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      dsr_q         <= dsr_d;
      csr_q         <= csr_d;
      d_q           <= d_d;
      crc_q         <= crc_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign d           = d_q;
  assign crc         = crc_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != IDLE);

endmodule
